// File: rtl/zoned_alarm_controller.sv
// Zoned alarm controller: perimeter/hub zones, exit/entry delays,
// siren timeout, validated WiFi commands and per-zone trip latching.
module zoned_alarm_controller #(
  parameter int N_ZONES = 4,
  parameter logic [N_ZONES-1:0] HUB_MASK = N_ZONES'(1),
  parameter int EXIT_CYC = 16,
  parameter int ENTRY_CYC = 16,
  parameter int SIREN_CYC = 64,
  parameter int CNT_W = 16,
  parameter int CMD_W = 4,
  parameter logic [CMD_W-1:0] CMD_DISARM = CMD_W'(4'b1010),
  parameter logic [CMD_W-1:0] CMD_ARM = CMD_W'(4'b1011),
  parameter logic [CMD_W-1:0] CMD_ESC = CMD_W'(4'b1100)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic [N_ZONES-1:0] zone,
  input  logic [CMD_W-1:0]   cmd,
  input  logic               cmd_valid,
  output logic               outWIFI_gf,
  output logic               siren_gf,
  output logic               lock_gf,
  output logic               inactive_gf,
  output logic               active_gf,
  output logic               alarm_gf,
  output logic               emergency_gf,
  output logic               delay_gf,
  output logic [2:0]         message_gf,
  output logic [N_ZONES-1:0] tripped_gf
);

  typedef enum logic [2:0] {
    S_INACTIVE = 3'd0,
    S_EXIT     = 3'd1,
    S_ACTIVE   = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4,
    S_EMERG    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_CYC - 1);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_CYC - 1);
  localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_CYC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [N_ZONES-1:0] trip, trip_nx;
  logic               sdone;
  logic               clr;
  logic               watch;

  logic dis, arm, esc, hub, per, cnt_z;

  assign dis   = cmd_valid && (cmd == CMD_DISARM);
  assign arm   = cmd_valid && (cmd == CMD_ARM);
  assign esc   = cmd_valid && (cmd == CMD_ESC);
  assign hub   = |(zone & HUB_MASK);
  assign per   = |(zone & ~HUB_MASK);
  assign cnt_z = (cnt == '0);

  // Next-state, counter and trip-clear decision in priority order
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    clr      = 1'b0;
    case (state)
      S_INACTIVE: begin
        if (init || arm) begin
          state_nx = S_EXIT;
          cnt_nx   = EXIT_LD;
          clr      = 1'b1;
        end
      end
      S_EXIT: begin
        if (dis) state_nx = S_INACTIVE;
        else if (cnt_z) state_nx = S_ACTIVE;
        else cnt_nx = cnt - ONE;
      end
      S_ACTIVE: begin
        if (dis) state_nx = S_INACTIVE;
        else if (hub) state_nx = S_EMERG;
        else if (per) begin
          state_nx = S_ENTRY;
          cnt_nx   = ENTRY_LD;
        end
        else if (esc) state_nx = S_EMERG;
      end
      S_ENTRY: begin
        if (dis) state_nx = S_INACTIVE;
        else if (hub || esc) state_nx = S_EMERG;
        else if (cnt_z) begin
          state_nx = S_ALARM;
          cnt_nx   = SIREN_LD;
        end
        else cnt_nx = cnt - ONE;
      end
      S_ALARM: begin
        if (dis) state_nx = S_INACTIVE;
        else if (arm) begin
          state_nx = S_EXIT;
          cnt_nx   = EXIT_LD;
          clr      = 1'b1;
        end
        else if (hub || esc) state_nx = S_EMERG;
        else if (!cnt_z) cnt_nx = cnt - ONE;
      end
      S_EMERG: begin
        if (dis) state_nx = S_INACTIVE;
        else if (arm) begin
          state_nx = S_EXIT;
          cnt_nx   = EXIT_LD;
          clr      = 1'b1;
        end
      end
      default: state_nx = S_INACTIVE;
    endcase
    if (state_nx == S_INACTIVE) clr = 1'b1;
  end

  assign watch = (state == S_ACTIVE) || (state == S_ENTRY) ||
                 (state == S_ALARM) || (state == S_EMERG);

  // Sticky trip bits; a clearing event wins over a same-cycle detect
  always_comb begin
    trip_nx = trip;
    if (clr) trip_nx = '0;
    else if (watch) trip_nx = trip | zone;
  end

  // Core state, counter, trip latch and siren-expired flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_INACTIVE;
      cnt   <= '0;
      trip  <= '0;
      sdone <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      trip  <= trip_nx;
      sdone <= (state == S_ALARM) && cnt_z;
    end
  end

  assign tripped_gf = trip;

  // Registered outputs decoded from the current state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outWIFI_gf   <= 1'b0;
      siren_gf     <= 1'b0;
      lock_gf      <= 1'b0;
      delay_gf     <= 1'b0;
      inactive_gf  <= 1'b1;
      active_gf    <= 1'b1;
      alarm_gf     <= 1'b1;
      emergency_gf <= 1'b1;
      message_gf   <= 3'd0;
    end else begin
      outWIFI_gf   <= (state == S_ALARM) || (state == S_EMERG);
      siren_gf     <= ((state == S_ALARM) && !sdone) ||
                      (state == S_EMERG);
      lock_gf      <= (state == S_EMERG);
      delay_gf     <= (state == S_EXIT) || (state == S_ENTRY);
      inactive_gf  <= !(state == S_INACTIVE);
      active_gf    <= !((state == S_EXIT) || (state == S_ACTIVE) ||
                        (state == S_ENTRY));
      alarm_gf     <= !(state == S_ALARM);
      emergency_gf <= !(state == S_EMERG);
      message_gf   <= state;
    end
  end

endmodule

// File: tb/tb_zoned_alarm_controller.sv
// Directed bench for zoned_alarm_controller: vector table plus
// hand sequences for emergency hold and asynchronous reset.
module tb_zoned_alarm_controller;

  logic       clk;
  logic       reset;
  logic       init;
  logic [3:0] zone;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       outWIFI_gf, siren_gf, lock_gf;
  logic       inactive_gf, active_gf, alarm_gf, emergency_gf;
  logic       delay_gf;
  logic [2:0] message_gf;
  logic [3:0] tripped_gf;

  int n_chk = 0;
  int n_fail = 0;

  zoned_alarm_controller #(
    .N_ZONES(4),
    .HUB_MASK(4'b0001),
    .EXIT_CYC(4),
    .ENTRY_CYC(3),
    .SIREN_CYC(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .init(init),
    .zone(zone),
    .cmd(cmd),
    .cmd_valid(cmd_valid),
    .outWIFI_gf(outWIFI_gf),
    .siren_gf(siren_gf),
    .lock_gf(lock_gf),
    .inactive_gf(inactive_gf),
    .active_gf(active_gf),
    .alarm_gf(alarm_gf),
    .emergency_gf(emergency_gf),
    .delay_gf(delay_gf),
    .message_gf(message_gf),
    .tripped_gf(tripped_gf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       init;
    logic [3:0] zone;
    logic [3:0] cmd;
    logic       cv;
    logic [2:0] msg;
    logic       siren;
    logic [3:0] trip;
  } vec_t;

  vec_t vq[$];

  localparam logic [14:0] RST_EXP = 15'b000_0000_1111_0000;

  function automatic logic [14:0] expv(input logic [2:0] m,
                                       input logic s,
                                       input logic [3:0] t);
    logic w, l, d, ia, ac, al, em;
    w  = (m == 3'd4) || (m == 3'd5);
    l  = (m == 3'd5);
    d  = (m == 3'd1) || (m == 3'd3);
    ia = (m != 3'd0);
    ac = !((m == 3'd1) || (m == 3'd2) || (m == 3'd3));
    al = (m != 3'd4);
    em = (m != 3'd5);
    return {m, s, w, l, d, ia, ac, al, em, t};
  endfunction

  function automatic logic [14:0] actv();
    return {message_gf, siren_gf, outWIFI_gf, lock_gf, delay_gf,
            inactive_gf, active_gf, alarm_gf, emergency_gf,
            tripped_gf};
  endfunction

  task automatic chk(input string nm, input logic [14:0] a,
                     input logic [14:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, a, e);
    end
  endtask

  task automatic step(input logic i, input logic [3:0] z,
                      input logic [3:0] c, input logic v);
    init = i;
    zone = z;
    cmd = c;
    cmd_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic i, input logic [3:0] z,
                     input logic [3:0] c, input logic v,
                     input logic [2:0] m, input logic s,
                     input logic [3:0] t);
    vec_t x;
    x.init = i; x.zone = z; x.cmd = c; x.cv = v;
    x.msg = m; x.siren = s; x.trip = t;
    vq.push_back(x);
  endtask

  initial begin
    bit ok;
    reset = 1'b1;
    init = 1'b0;
    zone = 4'b0;
    cmd = 4'b0;
    cmd_valid = 1'b0;

    // exit delay with a zone held, then entry delay into siren timeout
    add(0, 4'b0000, 4'h0, 0, 3'd0, 0, 4'b0000);
    add(1, 4'b0000, 4'h0, 0, 3'd0, 0, 4'b0000);
    for (int i = 0; i < 4; i++)
      add(0, 4'b0010, 4'h0, 0, 3'd1, 0, 4'b0000);
    add(0, 4'b0000, 4'h0, 0, 3'd2, 0, 4'b0000);
    add(0, 4'b0100, 4'h0, 0, 3'd2, 0, 4'b0100);
    for (int i = 0; i < 3; i++)
      add(0, 4'b0000, 4'h0, 0, 3'd3, 0, 4'b0100);
    for (int i = 0; i < 5; i++)
      add(0, 4'b0000, 4'h0, 0, 3'd4, 1, 4'b0100);
    add(0, 4'b0000, 4'h0, 0, 3'd4, 0, 4'b0100);
    add(0, 4'b0000, 4'h0, 0, 3'd4, 0, 4'b0100);
    // arm without qualifier ignored, then accepted
    add(0, 4'b0000, 4'hB, 0, 3'd4, 0, 4'b0100);
    add(0, 4'b0000, 4'hB, 1, 3'd4, 0, 4'b0000);
    for (int i = 0; i < 4; i++)
      add(0, 4'b0000, 4'h0, 0, 3'd1, 0, 4'b0000);
    add(0, 4'b0000, 4'h0, 0, 3'd2, 0, 4'b0000);
    // disarm during entry delay
    add(0, 4'b1000, 4'h0, 0, 3'd2, 0, 4'b1000);
    add(0, 4'b0000, 4'h0, 0, 3'd3, 0, 4'b1000);
    add(0, 4'b0000, 4'hA, 1, 3'd3, 0, 4'b0000);
    add(0, 4'b0000, 4'h0, 0, 3'd0, 0, 4'b0000);
    add(0, 4'b0000, 4'h0, 0, 3'd0, 0, 4'b0000);
    // rearm, then hub and perimeter together
    add(1, 4'b0000, 4'h0, 0, 3'd0, 0, 4'b0000);
    for (int i = 0; i < 4; i++)
      add(0, 4'b0000, 4'h0, 0, 3'd1, 0, 4'b0000);
    add(0, 4'b0000, 4'h0, 0, 3'd2, 0, 4'b0000);
    add(0, 4'b0011, 4'h0, 0, 3'd2, 0, 4'b0011);
    add(0, 4'b0000, 4'h0, 0, 3'd5, 1, 4'b0011);

    #2 reset = 1'b0;
    #1 chk("reset_values", actv(), RST_EXP);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    foreach (vq[k]) begin
      step(vq[k].init, vq[k].zone, vq[k].cmd, vq[k].cv);
      chk($sformatf("vec%0d", k), actv(),
          expv(vq[k].msg, vq[k].siren, vq[k].trip));
    end

    // emergency has no timeout and ignores escalate
    for (int i = 0; i < 110; i++) begin
      step(0, 4'b0000, 4'hC, i[0]);
      chk($sformatf("emerg%0d", i), actv(),
          expv(3'd5, 1'b1, 4'b0011));
    end

    // arm from emergency clears trips
    step(0, 4'b0000, 4'hB, 1);
    chk("emerg_arm", actv(), expv(3'd5, 1'b1, 4'b0000));

    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step(0, 4'b0000, 4'h0, 0);
      ok = (message_gf == 3'd2);
    end
    chk("reach_active", {14'd0, ok}, 15'd1);

    step(0, 4'b0100, 4'h0, 0);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step(0, 4'b0000, 4'h0, 0);
      ok = (message_gf == 3'd4);
    end
    chk("reach_alarm", {14'd0, ok}, 15'd1);
    chk("alarm_first", actv(), expv(3'd4, 1'b1, 4'b0100));

    // asynchronous reset mid-alarm, released between edges
    #3 reset = 1'b0;
    #1 chk("async_reset", actv(), RST_EXP);
    #2 reset = 1'b1;
    #1 chk("hold_to_edge", actv(), RST_EXP);
    step(0, 4'b0000, 4'h0, 0);
    chk("post_reset", actv(), expv(3'd0, 1'b0, 4'b0000));
    step(0, 4'b0000, 4'h0, 0);
    chk("post_reset2", actv(), expv(3'd0, 1'b0, 4'b0000));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
